// File: rtl/ir_sequencer.sv
// Instruction sequencer: owns the PC, issues single-word fetches, and holds each
// returned word in the IR until the fetch stage accepts it. Handles start/halt/jump.
module ir_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic                  i_halt,
  input  logic                  i_jump_en,
  input  logic [ADDR_WIDTH-1:0] i_jump_addr,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_ir,
  output logic                  o_ir_regfile_en,
  input  logic                  i_ir_ready,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [DATA_WIDTH-1:0]   ir;
  logic                    discard;
  logic                    halt_pend;
  logic                    halt_now;

  assign halt_now = halt_pend | i_halt;

  // NOTE: all state uses non-blocking assignments so every branch sees the
  // pre-edge values of pc/state/discard regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      discard   <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          halt_pend <= 1'b0;
          discard   <= 1'b0;
          if (i_start) begin
            pc    <= i_start_addr;
            state <= REQ;
          end
        end

        REQ: begin
          if (i_halt) halt_pend <= 1'b1;
          if (i_jump_en) begin
            pc <= i_jump_addr;
            // A grant in the jump cycle fetched the old address; drop its data.
            if (i_mem_gnt) begin
              state   <= WAIT;
              discard <= 1'b1;
            end
          end else if (i_mem_gnt) begin
            state <= WAIT;
          end else if (halt_now) begin
            state <= IDLE;
          end
        end

        WAIT: begin
          if (i_halt)    halt_pend <= 1'b1;
          if (i_jump_en) pc        <= i_jump_addr;
          if (i_mem_rvalid) begin
            if (discard || i_jump_en) begin
              discard <= 1'b0;
              state   <= REQ;
            end else begin
              ir    <= i_mem_rdata;
              state <= HOLD;
            end
          end else if (i_jump_en) begin
            discard <= 1'b1;
          end
        end

        HOLD: begin
          if (i_halt) halt_pend <= 1'b1;
          // Jump drops the held word and wins over the PC increment.
          if (i_jump_en || i_ir_ready) begin
            pc    <= i_jump_en ? i_jump_addr : pc + ADDR_WIDTH'(1);
            state <= halt_now ? IDLE : REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign o_mem_req       = (state == REQ);
  assign o_mem_addr      = pc;
  assign o_pc            = pc;
  assign o_ir            = ir;
  assign o_ir_regfile_en = (state == HOLD);
  assign o_busy          = (state != IDLE);

endmodule

// File: doc/ir_sequencer.md
# ir_sequencer

Instruction sequencer directly upstream of the operand fetch stage. Holds the program counter, issues single-word read requests to instruction memory, and captures each returned word into an instruction register. It presents each word on `o_ir` with `o_ir_regfile_en` until the fetch stage accepts it. It also handles start, halt and jump (PC reload) with discard of stale in-flight reads.

## Interface
- `DATA_WIDTH`, 16, instruction word width; must equal the codebase `DATA_WIDTH`.
- `ADDR_WIDTH`, 16, instruction memory address width.
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  pulse; accepted only in IDLE.
- `i_start_addr`  in  ADDR_WIDTH  PC value loaded on start.
- `i_halt`  in  1  request to stop after the current word.
- `i_jump_en`  in  1  reload PC; ignored in IDLE.
- `i_jump_addr`  in  ADDR_WIDTH  new PC value.
- `o_mem_req`  out  1  read request.
- `o_mem_addr`  out  ADDR_WIDTH  read address; equals `o_pc`.
- `i_mem_gnt`  in  1  request accepted this cycle.
- `i_mem_rvalid`  in  1  read data valid; exactly one per grant, at least 1 cycle after the grant.
- `i_mem_rdata`  in  DATA_WIDTH  read data.
- `o_ir`  out  DATA_WIDTH  instruction register.
- `o_ir_regfile_en`  out  1  `o_ir` valid, offered to the fetch stage.
- `i_ir_ready`  in  1  fetch stage accepts `o_ir`.
- `o_pc`  out  ADDR_WIDTH  current program counter.
- `o_busy`  out  1  high in any state except IDLE.

## Operation
- States: IDLE, REQ, WAIT, HOLD. Encoding is 2-bit. Illegal encodings go to IDLE.
- **IDLE**
  - No request. `halt_pend` is cleared.
  - `i_start` → PC ← `i_start_addr`, go to REQ.
- **REQ**
  - `o_mem_req`=1, `o_mem_addr`=PC.
  - If `i_mem_gnt` → WAIT.
  - Else if `i_halt` or `halt_pend` → IDLE.
- **WAIT**
  - On `i_mem_rvalid` with `discard`=0: IR ← `i_mem_rdata`, go to HOLD.
  - On `i_mem_rvalid` with `discard`=1: data dropped, `discard` cleared, go to REQ.
- **HOLD**
  - `o_ir_regfile_en`=1; `o_ir` held stable.
  - `i_ir_ready` → PC ← PC+1.
    - Next state is IDLE if `halt_pend` or `i_halt`.
    - Otherwise next state is REQ.
- **Jump** (`i_jump_en` in REQ, WAIT or HOLD): PC ← `i_jump_addr`. Jump has priority over `i_ir_ready` and over the PC increment.
  - REQ, no grant: stay in REQ; the next cycle presents the new address.
  - REQ with simultaneous `i_mem_gnt`: the granted read used the old address. Go to WAIT with `discard`=1.
  - WAIT, no rvalid: `discard` ← 1.
  - WAIT with simultaneous rvalid: data dropped, go to REQ.
  - HOLD: IR word dropped (`o_ir_regfile_en` low next cycle), go to REQ; halt still honoured.
- **Halt**: `i_halt` sets `halt_pend` in any non-IDLE state. In-flight reads always complete. A word in HOLD is always delivered unless a jump drops it.
- **PC arithmetic**: PC+1 is modulo 2^ADDR_WIDTH, so all-ones wraps to 0.
- `i_start` outside IDLE is ignored.

## Timing
- Reset (async assert, synchronous release):
  - State=IDLE; PC, IR, `discard` and `halt_pend` are 0.
  - `o_mem_req`, `o_ir_regfile_en` and `o_busy` are 0. `o_ir`=0, `o_pc`=0, `o_mem_addr`=0.
- All outputs are decoded from registers; there is no combinational input→output path.
- **Start to request**: `i_start` at edge N → `o_mem_req` high from cycle N+1.
- **Read to presentation**: rvalid at edge N → `o_ir_regfile_en` high and `o_ir` valid from cycle N+1.
- **Hand-off**: `o_ir_regfile_en`&`i_ir_ready` at edge N → next `o_mem_req` at N+1 with PC+1.
- **Throughput**: with 1-cycle memory latency and `i_ir_ready` tied high, one word every 3 cycles (REQ, WAIT, HOLD).
- **Backpressure**: while `i_ir_ready`=0, `o_ir`/`o_ir_regfile_en` hold indefinitely and no new request is issued.
- **Reset mid-operation**: an outstanding memory read may return after release. In IDLE, `i_mem_rvalid` is ignored.

## Test plan
- **Sequential fetch**: start at 0x0010; memory returns 0xA000+addr with 1-cycle latency; ready tied high. Required: IR sequence 0xA010, 0xA011, 0xA012, one word per 3 cycles, `o_pc` ends 0x0013.
- **Backpressure**: hold `i_ir_ready`=0 for 5 cycles in HOLD. Required: `o_ir` stable, `o_mem_req`=0 throughout, PC unchanged; the ready pulse advances PC by exactly 1.
- **Jump races**:
  - Jump to 0x0200 in the same cycle as a grant for 0x0011. Required: the returned 0xA011 is never presented; the next request has `o_mem_addr`=0x0200 and the next IR is 0xA200.
  - Repeat with the jump coincident with rvalid, and with the jump in HOLD together with `i_ir_ready`. Required: PC=0x0200, not 0x0201.
- **Halt**: assert `i_halt` during WAIT. Required: the word is delivered, PC increments once on acceptance, then IDLE with `o_busy`=0 and no further request.
- **Wrap and reset**:
  - Start at 0xFFFF. Required: after acceptance the next `o_mem_addr` is 0x0000.
  - Assert `rst_n`=0 mid-WAIT. Required: all outputs 0 immediately (asynchronously); a late rvalid after release is ignored.
